vram_write_arbiter: RTL
=======================

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter VRAM_BASE, default 2048: lowest legal VRAM address.
REQ-002 SHALL have parameter VRAM_TOP, default 8191: highest legal VRAM address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req  input  1, cpu_addr  input  13, cpu_data  input  8, cpu_ack  output  1: the CPU byte-write requester.
REQ-006 SHALL have ports blt_req  input  1, blt_addr  input  13, blt_sel  input  1, blt_nib  input  4, blt_ack  output  1: the blitter nibble-write requester.
REQ-007 SHALL have ports fill_start  input  1, fill_base  input  13, fill_len  input  13, fill_data  input  8, fill_busy  output  1, fill_done  output  1: the fill engine.
REQ-008 SHALL have ports err  output  1 (sticky range error) and err_clr  input  1.
REQ-009 SHALL have VRAM-side ports waddr  output  13, w  output  1, in  output  8, ws  output  1, sel  output  1, ins  output  4.

Function
REQ-010 All outputs SHALL be registered; w and ws SHALL never be high in the same cycle.
REQ-011 Handshake: a requester SHALL hold req and its payload stable until ack; ack SHALL be a one-cycle pulse, coincident with the corresponding w or ws cycle.
REQ-012 A requester whose ack is high in the current cycle SHALL NOT be granted at the next edge, so each requester gets at most 1 write per 2 cycles.
REQ-013 With the FSM in IDLE and both cpu_req and blt_req eligible, grant SHALL go round-robin, starting with CPU after reset; a single eligible requester SHALL be granted immediately.
REQ-014 A CPU grant SHALL drive w=1, waddr=cpu_addr, in=cpu_data for one cycle, with cpu_ack=1 in that cycle.
REQ-015 A blitter grant SHALL drive ws=1, waddr=blt_addr, sel=blt_sel, ins=blt_nib for one cycle, with blt_ack=1 in that cycle.
REQ-016 The FSM SHALL have states IDLE and FILL; fill_start sampled in IDLE SHALL latch fill_base, fill_len and fill_data, and enter FILL on the same edge.
REQ-016a fill_start SHALL take priority over CPU and blitter grants on that edge.
REQ-017 In FILL, the block SHALL drive w=1, in=latched data and waddr=base+k on cycle k (k=0..len-1), one write per cycle; fill_busy=1 throughout FILL.
REQ-018 In FILL, CPU and blitter SHALL NOT be granted; their requests SHALL wait, without being lost.
REQ-019 After the last fill write, the FSM SHALL return to IDLE, and fill_done SHALL pulse for 1 cycle on the first IDLE cycle.
REQ-019a fill_busy SHALL drop on that same cycle, and arbitration SHALL resume on that same edge.
REQ-020 fill_len=0 SHALL produce no writes, 1 cycle of FILL with fill_busy=1, then fill_done.
REQ-021 fill_start while in FILL SHALL be ignored.
REQ-022 Fill addresses SHALL NOT wrap: if base+k would exceed VRAM_TOP, the fill SHALL terminate (done pulse as normal) and set err.
REQ-023 A CPU or blitter request with an address outside VRAM_BASE..VRAM_TOP SHALL be acked normally.
REQ-023a For such a request, w and ws SHALL stay 0, and err SHALL be set.
REQ-024 A fill with fill_base out of range SHALL perform no writes, set err and complete with fill_done.
REQ-025 err SHALL be sticky; err_clr SHALL clear it next edge; a new error on the same edge as err_clr SHALL win (err stays 1).
REQ-026 Address arithmetic SHALL be 14-bit internally, so base+k overflow past 8191 is detected, not wrapped.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, round-robin pointer=CPU, and err=0.
REQ-027a rst low SHALL also force w=ws=0, cpu_ack=blt_ack=0, fill_busy=fill_done=0, and waddr=in=ins=sel=0.
REQ-028 Reset mid-FILL SHALL abort the fill without a fill_done pulse.
REQ-028a The first grant after rst rises SHALL occur no earlier than the second posedge.

Verification
REQ-029 cpu_req with addr=2048 and data=0xA5, no other traffic -> next cycle w=1, waddr=2048, in=0xA5, cpu_ack=1, for exactly 1 cycle.
REQ-030 cpu_req and blt_req held continuously -> writes alternate: cycle1 CPU, cycle2 blitter, cycle3 CPU, ...; each ack 1 per 2 cycles.
REQ-030a In that scenario, w and ws SHALL never both be high in any cycle.
REQ-031 fill_start with base=8000, len=4, data=0x11, plus cpu_req pending -> waddr 8000..8003 with w=1 on 4 consecutive cycles.
REQ-031a In that scenario, fill_done SHALL pulse on the next cycle, and the CPU write SHALL follow on that same cycle.
REQ-032 fill with base=8190, len=5 -> writes at 8190 and 8191 only, fill_done pulses, err=1; err_clr -> err=0.
REQ-033 blt_req with addr=100 -> blt_ack pulses, ws stays 0, err=1.
REQ-034 Assert rst during the third cycle of a 10-word fill -> all outputs 0 immediately, no fill_done pulse.
REQ-034a After rst rises in that scenario, a new fill_start SHALL be accepted.

Source files
------------

// File: rtl/vram_write_arbiter_if.sv
// Signal bundle between the CPU/blitter/fill requesters and vram_write_arbiter,
// plus the registered VRAM write port and a debug view of the FSM state.
interface vram_write_arbiter_if;
    // Handshake: a requester raises req with its payload and holds both stable
    // until it sees ack; ack is a one-cycle pulse in the same cycle as the
    // resulting w/ws (or the suppressed write for an out-of-range address), and
    // a requester is never granted on the edge right after its own ack.
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;

    logic        blt_req;
    logic [12:0] blt_addr;
    logic        blt_sel;
    logic [3:0]  blt_nib;
    logic        blt_ack;

    logic        fill_start;
    logic [12:0] fill_base;
    logic [12:0] fill_len;
    logic [7:0]  fill_data;
    logic        fill_busy;
    logic        fill_done;

    logic        err;
    logic        err_clr;

    logic [12:0] waddr;
    logic        w;
    logic [7:0]  in;
    logic        ws;
    logic        sel;
    logic [3:0]  ins;

    logic        fsm_state;

    modport slave (
        input  cpu_req, cpu_addr, cpu_data, blt_req, blt_addr, blt_sel, blt_nib,
               fill_start, fill_base, fill_len, fill_data, err_clr,
        output cpu_ack, blt_ack, fill_busy, fill_done, err,
               waddr, w, in, ws, sel, ins, fsm_state
    );

    modport master (
        output cpu_req, cpu_addr, cpu_data, blt_req, blt_addr, blt_sel, blt_nib,
               fill_start, fill_base, fill_len, fill_data, err_clr,
        input  cpu_ack, blt_ack, fill_busy, fill_done, err,
               waddr, w, in, ws, sel, ins, fsm_state
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Arbitrates CPU byte writes, blitter nibble writes and a block-fill engine onto
// one registered VRAM write port, with range checking and a sticky error flag.
module vram_write_arbiter #(
    parameter int VRAM_BASE = 2048,
    parameter int VRAM_TOP  = 8191
) (
    input  logic                 clk,
    input  logic                 rst,
    vram_write_arbiter_if.slave  bus
);
    localparam logic [13:0] BASE_A = 14'(VRAM_BASE);
    localparam logic [13:0] TOP_A  = 14'(VRAM_TOP);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t      state, state_n;
    logic        run;
    logic        rr, rr_n;
    logic [13:0] fill_addr, fill_addr_n, fill_next;
    logic [12:0] fill_left, fill_left_n;
    logic [7:0]  fill_data_q, fill_data_n;

    logic        w_q, w_n, ws_q, ws_n;
    logic        cpu_ack_q, cpu_ack_n, blt_ack_q, blt_ack_n;
    logic        busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic [12:0] waddr_q, waddr_n;
    logic [7:0]  in_q, in_n;
    logic        sel_q, sel_n;
    logic [3:0]  ins_q, ins_n;

    logic        arb, err_set, cpu_elig, blt_elig;

    function automatic logic in_range(input logic [13:0] a);
        return (a >= BASE_A) && (a <= TOP_A);
    endfunction

    // 14-bit so stepping past the top of the address space is seen, not wrapped.
    assign fill_next = fill_addr + 14'd1;
    assign cpu_elig  = bus.cpu_req && !cpu_ack_q;
    assign blt_elig  = bus.blt_req && !blt_ack_q;

    always_comb begin
        state_n     = state;
        rr_n        = rr;
        fill_addr_n = fill_addr;
        fill_left_n = fill_left;
        fill_data_n = fill_data_q;
        w_n         = 1'b0;
        ws_n        = 1'b0;
        cpu_ack_n   = 1'b0;
        blt_ack_n   = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        waddr_n     = waddr_q;
        in_n        = in_q;
        sel_n       = sel_q;
        ins_n       = ins_q;
        arb         = 1'b0;
        err_set     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run && bus.fill_start) begin
                    state_n     = S_FILL;
                    busy_n      = 1'b1;
                    fill_addr_n = {1'b0, bus.fill_base};
                    fill_data_n = bus.fill_data;
                    waddr_n     = bus.fill_base;
                    in_n        = bus.fill_data;
                    fill_left_n = 13'd0;
                    if (!in_range({1'b0, bus.fill_base})) begin
                        err_set = 1'b1;
                    end else if (bus.fill_len != 13'd0) begin
                        w_n         = 1'b1;
                        fill_left_n = bus.fill_len - 13'd1;
                    end
                end else if (run) begin
                    arb = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_left == 13'd0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    arb     = 1'b1;
                end else if (fill_next > TOP_A) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    err_set = 1'b1;
                    arb     = 1'b1;
                end else begin
                    busy_n      = 1'b1;
                    w_n         = 1'b1;
                    fill_addr_n = fill_next;
                    fill_left_n = fill_left - 13'd1;
                    waddr_n     = fill_next[12:0];
                    in_n        = fill_data_q;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // rr=0 means the CPU wins a tie; it flips to the other side after any grant.
        if (arb) begin
            if (cpu_elig && (!blt_elig || !rr)) begin
                cpu_ack_n = 1'b1;
                rr_n      = 1'b1;
                waddr_n   = bus.cpu_addr;
                in_n      = bus.cpu_data;
                if (in_range({1'b0, bus.cpu_addr})) w_n = 1'b1;
                else                                err_set = 1'b1;
            end else if (blt_elig) begin
                blt_ack_n = 1'b1;
                rr_n      = 1'b0;
                waddr_n   = bus.blt_addr;
                sel_n     = bus.blt_sel;
                ins_n     = bus.blt_nib;
                if (in_range({1'b0, bus.blt_addr})) ws_n = 1'b1;
                else                                err_set = 1'b1;
            end
        end

        err_n = (err_q && !bus.err_clr) || err_set;
    end

    // run holds off all grants until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            run         <= 1'b0;
            rr          <= 1'b0;
            fill_addr   <= '0;
            fill_left   <= '0;
            fill_data_q <= '0;
            w_q         <= 1'b0;
            ws_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            blt_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            waddr_q     <= '0;
            in_q        <= '0;
            sel_q       <= 1'b0;
            ins_q       <= '0;
        end else begin
            state       <= state_n;
            run         <= 1'b1;
            rr          <= rr_n;
            fill_addr   <= fill_addr_n;
            fill_left   <= fill_left_n;
            fill_data_q <= fill_data_n;
            w_q         <= w_n;
            ws_q        <= ws_n;
            cpu_ack_q   <= cpu_ack_n;
            blt_ack_q   <= blt_ack_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            err_q       <= err_n;
            waddr_q     <= waddr_n;
            in_q        <= in_n;
            sel_q       <= sel_n;
            ins_q       <= ins_n;
        end
    end

    assign bus.w         = w_q;
    assign bus.ws        = ws_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.blt_ack   = blt_ack_q;
    assign bus.fill_busy = busy_q;
    assign bus.fill_done = done_q;
    assign bus.err       = err_q;
    assign bus.waddr     = waddr_q;
    assign bus.in        = in_q;
    assign bus.sel       = sel_q;
    assign bus.ins       = ins_q;
    assign bus.fsm_state = (state == S_FILL);
endmodule
